// File: rtl/rv_pkg.sv
// Shared types for the sequential comparator: ALU compare op codes, FSM states,
// and the op-to-boolean result mapping.
package rv_pkg;

  typedef enum logic [2:0] {
    ALU_EQ  = 3'd0,
    ALU_NE  = 3'd1,
    ALU_LT  = 3'd2,
    ALU_GE  = 3'd3,
    ALU_MIN = 3'd4,
    ALU_MAX = 3'd5
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // MIN/MAX report 1 when operand a is the selected one; unknown codes give 0.
  function automatic logic op_res(input cmp_op_e op, input logic lt, input logic eq);
    logic r;
    r = 1'b0;
    case (op)
      ALU_EQ:  r = eq;
      ALU_NE:  r = ~eq;
      ALU_LT:  r = lt;
      ALU_GE:  r = ~lt;
      ALU_MIN: r = lt;
      ALU_MAX: r = ~lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv_cmp_chunk.sv
// Combinational compare of one CHUNK-wide slice. With top_sign set the slice MSB
// is treated as the two's-complement sign bit of the whole operand.
module rv_cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             top_sign,
  output logic             diff,
  output logic             lt
);

  always_comb begin
    diff = (a != b);
    // Opposite signs decide on their own; same signs fall back to unsigned order.
    if (top_sign && (a[CHUNK-1] != b[CHUNK-1])) begin
      lt = a[CHUNK-1];
    end else begin
      lt = (a < b);
    end
  end

endmodule

// File: rtl/rv_compare_seq.sv
// Multi-cycle MSB-first comparator / min-max unit. Walks the operands CHUNK bits
// per cycle, optionally stopping at the first differing chunk.
module rv_compare_seq
  import rv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  cmp_op_e          in_op,
  input  logic             in_sign,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_res,
  output logic [WIDTH-1:0] out_data,
  output cmp_state_e       state_dbg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; out_valid and its payload hold steady until out_ready is seen.

  cmp_state_e       state, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  cmp_op_e          op_q;
  logic             sign_q;
  logic [IW-1:0]    idx;
  logic             seen_q, lt_q;

  logic [CHUNK-1:0] ca, cb;
  logic             cdiff, clt, last, accept;
  logic             fin_lt, fin_eq, fin_res, sel_a;
  logic [WIDTH-1:0] fin_data;

  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  rv_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (ca),
    .b        (cb),
    .top_sign (sign_q && (idx == TOP_IDX)),
    .diff     (cdiff),
    .lt       (clt)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;
  assign accept    = in_valid && in_ready && !flush;
  assign last      = ((EARLY_EXIT != 0) && cdiff) || (idx == '0);

  // The first differing chunk (MSB side) decides ordering; later ones are ignored.
  always_comb begin
    fin_lt  = seen_q ? lt_q : (cdiff && clt);
    fin_eq  = !(seen_q || cdiff);
    fin_res = op_res(op_q, fin_lt, fin_eq);
    sel_a   = (op_q == ALU_MIN) ? fin_lt : !fin_lt;
    if ((op_q == ALU_MIN) || (op_q == ALU_MAX)) begin
      fin_data = sel_a ? a_q : b_q;
    end else begin
      fin_data = WIDTH'(fin_res);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_EQ;
      sign_q   <= 1'b0;
      idx      <= TOP_IDX;
      seen_q   <= 1'b0;
      lt_q     <= 1'b0;
      out_res  <= 1'b0;
      out_data <= '0;
    end else if (flush) begin
      idx    <= TOP_IDX;
      seen_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= in_a;
            b_q    <= in_b;
            op_q   <= in_op;
            sign_q <= in_sign;
            idx    <= TOP_IDX;
            seen_q <= 1'b0;
            lt_q   <= 1'b0;
          end
        end
        RUN: begin
          if (cdiff && !seen_q) begin
            seen_q <= 1'b1;
            lt_q   <= clt;
          end
          if (last) begin
            out_res  <= fin_res;
            out_data <= fin_data;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
